// File: rtl/jk_ff.sv
// Single-bit JK flip-flop. The response to each J/K combination is set by
// parameters, so one primitive covers toggle flags and set/clear status bits.
module jk_ff #(
   parameter logic HOLD   = 1'b0,
   parameter logic TOGGLE = 1'b1,
   parameter logic SET    = 1'b1,
   parameter logic RESET  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic J,
   input  logic K,
   output logic Q
);

   logic q_q;
   logic q_d;

   // An unknown J/K matches no case item, so the default holds the state.
   // This keeps an X on the inputs out of the register.
   always_comb begin
      q_d = q_q;
      case ({J, K})
         2'b00:   q_d = q_q ^ HOLD;
         2'b01:   q_d = RESET;
         2'b10:   q_d = SET;
         2'b11:   q_d = q_q ^ TOGGLE;
         default: q_d = q_q;
      endcase
   end

   // rst_n is active-high. An X on it fails the if-test and falls through to the data path.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         q_q <= RESET;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q = q_q;

endmodule

// File: tb/tb_jk_ff.sv
// Scoreboard bench for jk_ff: a default instance and a fully overridden instance
// share one stimulus stream. Expected Q values are queued on the driving edge.
module tb_jk_ff;

   logic clk = 1'b0;
   logic rst_n;
   logic J;
   logic K;
   logic q_a;
   logic q_b;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string tag;
      logic  exp_a;
      logic  exp_b;
      bit    chk_b;
   } sb_entry_t;

   sb_entry_t sb_q[$];

   logic model_a;
   logic model_b;

   always #5 clk = ~clk;

   jk_ff u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .J     (J),
      .K     (K),
      .Q     (q_a)
   );

   jk_ff #(
      .HOLD   (1'b1),
      .TOGGLE (1'b0),
      .SET    (1'b0),
      .RESET  (1'b1)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .J     (J),
      .K     (K),
      .Q     (q_b)
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   // Reference next-state used by the random phase.
   function automatic logic ref_next(input logic q, input logic r, input logic j, input logic k,
                                     input logic h, input logic t, input logic s, input logic c);
      if (r) return c;
      if (!j && !k) return q ^ h;
      if (!j && k) return c;
      if (j && !k) return s;
      return q ^ t;
   endfunction

   // Drive on the falling edge, queue the expectation, compare just after the rising edge.
   task automatic step(input string tag, input logic r, input logic j, input logic k,
                       input logic ea, input logic eb, input bit cb);
      sb_entry_t e;
      @(negedge clk);
      rst_n = r;
      J = j;
      K = k;
      sb_q.push_back('{tag: tag, exp_a: ea, exp_b: eb, chk_b: cb});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_bit({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = sb_q.pop_front();
         $display("[TB] %-10s rst=%b J=%b K=%b -> Qa=%b (exp %b) Qb=%b (exp %b%s)",
                  e.tag, r, j, k, q_a, e.exp_a, q_b, e.exp_b, e.chk_b ? "" : ", unchecked");
         check_bit({e.tag, "_a"}, q_a, e.exp_a);
         if (e.chk_b) check_bit({e.tag, "_b"}, q_b, e.exp_b);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      tests_failed++;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      J = 1'b0;
      K = 1'b0;

      // Reset and hold/clear/set
      step("rst",      1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step("hold0",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("hold1",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("clr",      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      step("set",      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step("clr2",     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Set then toggle four edges
      step("rst2",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("set2",     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step("tog0",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step("tog1",     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      step("tog2",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step("tog3",     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

      // Reset wins mid-toggle, toggling resumes afterwards
      step("rst_tog",  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step("tog_res",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step("hold_a",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step("hold_b",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

      // Unknown K with J=0 must not disturb Q
      step("rst3",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step("kx0",      1'b0, 1'b0, 1'bx, 1'b0, 1'b0, 1'b0);
      step("kx1",      1'b0, 1'b0, 1'bx, 1'b0, 1'b0, 1'b0);

      // Inputs wiggling between edges leave Q untouched
      for (int i = 0; i < 3; i++) begin
         J = 1'b1; K = 1'b0;
         #1 check_bit("glitch_set", q_a, 1'b0);
         J = 1'b1; K = 1'b1; rst_n = 1'b1;
         #0.5 check_bit("glitch_tog", q_a, 1'b0);
         rst_n = 1'b0;
      end

      // Random phase against the reference model
      step("rst4",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      model_a = 1'b0;
      model_b = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic r, j, k;
         r = ($urandom_range(0, 7) == 0);
         j = 1'($urandom_range(0, 1));
         k = 1'($urandom_range(0, 1));
         model_a = ref_next(model_a, r, j, k, 1'b0, 1'b1, 1'b1, 1'b0);
         model_b = ref_next(model_b, r, j, k, 1'b1, 1'b0, 1'b0, 1'b1);
         step($sformatf("rnd%0d", i), r, j, k, model_a, model_b, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
